tiny_cpu: RTL and testbench

- Minimal 32-bit RV32I-subset CPU that runs a fixed program from internal instruction ROM.
- Executes one instruction per slow tick; the tick comes from an internal divider of the board clock.
- Uses an internal 32-word data RAM and a 32x32 register file, and drives three active-low RGB LEDs from register x5.
- Top-level board block; the only inputs are clock and reset.

---
 rtl/tiny_cpu_pkg.sv | 52 +++++
 rtl/tiny_cpu_alu.sv | 31 +++
 rtl/tiny_cpu.sv | 153 +++++++++++++++
 tb/tb_tiny_cpu.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tiny_cpu_pkg.sv
// tiny_cpu_pkg: shared definitions for the tiny RV32I-subset CPU.
//   - opcode / funct3 / funct7 constants
//   - ALU operation enum
//   - rom_word(): fixed program image (unused words hold a NOP)
package tiny_cpu_pkg;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6F;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  // funct7 value selecting SUB / SRA; only bit 5 (IR[30]) distinguishes it
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  function automatic logic [31:0] rom_word(input int unsigned idx);
    case (idx)
      0:       return 32'h0050_0093;  // addi x1,x0,5
      1:       return 32'h0030_0113;  // addi x2,x0,3
      2:       return 32'h0020_81B3;  // add  x3,x1,x2
      3:       return 32'h4021_0233;  // sub  x4,x2,x2
      4:       return 32'h0011_8293;  // addi x5,x3,1
      5:       return 32'h02A0_0313;  // addi x6,x0,42
      6:       return 32'h0000_0393;  // addi x7,x0,0
      7:       return 32'h0063_A023;  // sw   x6,0(x7)
      8:       return 32'h0003_A403;  // lw   x8,0(x7)
      9:       return 32'h0000_006F;  // jal  x0,0
      default: return NOP_INSN;
    endcase
  endfunction

endpackage

// File: rtl/tiny_cpu_alu.sv
// tiny_cpu_alu: combinational ALU.
//   a, b    : operands (b is rs2 or the sign-extended immediate)
//   alu_op  : operation select
//   result  : 32-bit result, arithmetic wraps, shifts use b[4:0]
module tiny_cpu_alu
  import tiny_cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     alu_op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'd0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = 32'($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/tiny_cpu.sv
// tiny_cpu: single-cycle RV32I-subset CPU running a fixed ROM program.
//   CLK       : board clock
//   RESET     : synchronous, active-high
//   led_red   : ~x5[0] (active low)
//   led_green : ~x5[1] (active low)
//   led_blue  : ~x5[2] (active low)
// Architectural state advances once per slow cycle, on the CLK edge where
// the divided clock slow_clk rises. All state has power-up values equal to
// its reset values so the board runs with RESET tied low.
module tiny_cpu
  import tiny_cpu_pkg::*;
#(
  parameter int CLK_DIV_LOG2 = 4,
  parameter int ROM_WORDS    = 32,
  parameter int RAM_WORDS    = 32
) (
  input  logic CLK,
  input  logic RESET,
  output logic led_red,
  output logic led_green,
  output logic led_blue
);

  localparam int ROM_AW = $clog2(ROM_WORDS);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam logic [31:0] PC_MASK = 32'(ROM_WORDS * 4 - 1);

  logic [CLK_DIV_LOG2-1:0] div_cnt = '0;
  logic [CLK_DIV_LOG2-1:0] div_nxt;
  logic                    slow_clk, tick;

  logic [31:0] PC = '0;
  logic [31:0] IR;
  logic [31:0] R   [0:31]          = '{default: '0};
  logic [31:0] RAM [0:RAM_WORDS-1] = '{default: '0};

  // divider: tick is the CLK edge on which the counter MSB goes 0->1
  assign div_nxt  = div_cnt + 1'b1;
  assign slow_clk = div_cnt[CLK_DIV_LOG2-1];
  assign tick     = ~div_cnt[CLK_DIV_LOG2-1] & div_nxt[CLK_DIV_LOG2-1];

  assign IR = rom_word(int'(PC[ROM_AW+1:2]));

  // decode
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] rs1_val, rs2_val;

  assign opcode = IR[6:0];
  assign rd     = IR[11:7];
  assign f3     = IR[14:12];
  assign rs1    = IR[19:15];
  assign rs2    = IR[24:20];
  assign imm_i  = {{20{IR[31]}}, IR[31:20]};
  assign imm_s  = {{20{IR[31]}}, IR[31:25], IR[11:7]};
  assign imm_b  = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
  assign imm_j  = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? '0 : R[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : R[rs2];

  // ALU
  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_res;

  always_comb begin
    alu_op = ALU_ADD;
    case (f3)
      F3_ADD:  alu_op = (opcode == OP && IR[30] == F7_ALT[5]) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_op = ALU_SLL;
      F3_SLT:  alu_op = ALU_SLT;
      F3_SLTU: alu_op = ALU_SLTU;
      F3_XOR:  alu_op = ALU_XOR;
      F3_SR:   alu_op = (IR[30] == F7_ALT[5]) ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_op = ALU_OR;
      F3_AND:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  assign alu_b = (opcode == OP) ? rs2_val : imm_i;

  tiny_cpu_alu u_alu (
    .a      (rs1_val),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_res)
  );

  // data memory: word index wraps within RAM, byte offset ignored
  logic [31:0]       mem_addr, load_data;
  logic [RAM_AW-1:0] mem_idx;

  assign mem_addr  = rs1_val + ((opcode == STORE) ? imm_s : imm_i);
  assign mem_idx   = mem_addr[RAM_AW+1:2];
  assign load_data = RAM[mem_idx];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:RAM_AW+2], mem_addr[1:0]};

  // control / writeback / next PC
  logic        rf_we, ram_we;
  logic [31:0] rf_wd, pc_plus4, pc_nxt;

  assign pc_plus4 = PC + 32'd4;

  always_comb begin
    rf_we  = 1'b0;
    ram_we = 1'b0;
    rf_wd  = alu_res;
    pc_nxt = pc_plus4;
    case (opcode)
      OP_IMM, OP: rf_we = 1'b1;
      LOAD:  if (f3 == F3_W) begin rf_we = 1'b1; rf_wd = load_data; end
      STORE: if (f3 == F3_W) ram_we = 1'b1;
      BRANCH: begin
        if ((f3 == F3_BEQ && rs1_val == rs2_val) ||
            (f3 == F3_BNE && rs1_val != rs2_val))
          pc_nxt = PC + imm_b;
      end
      JAL: begin
        rf_we  = 1'b1;
        rf_wd  = pc_plus4;
        pc_nxt = PC + imm_j;
      end
      default: ;  // undecoded opcode: NOP
    endcase
  end

  // RESET takes priority over a tick landing on the same edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt <= '0;
      PC      <= '0;
      for (int i = 0; i < 32; i++) R[i] <= '0;
      for (int i = 0; i < RAM_WORDS; i++) RAM[i] <= '0;
    end else begin
      div_cnt <= div_nxt;
      if (tick) begin
        PC <= pc_nxt & PC_MASK;
        if (rf_we && rd != 5'd0) R[rd] <= rf_wd;
        if (ram_we) RAM[mem_idx] <= rs2_val;
      end
    end
  end

  assign led_red   = ~R[5][0];
  assign led_green = ~R[5][1];
  assign led_blue  = ~R[5][2];

endmodule

// File: tb/tb_tiny_cpu.sv
// tb_tiny_cpu: scoreboard bench for tiny_cpu.
// Stimulus pushes expected PC values per tick into pc_q and expected state
// snapshots into st_q; the monitor pops pc_q on every slow_clk rise and
// drains st_q at every falling CLK edge.
module tb_tiny_cpu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic led_red, led_green, led_blue;

  tiny_cpu #(.CLK_DIV_LOG2(4), .ROM_WORDS(32), .RAM_WORDS(32)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .led_red   (led_red),
    .led_green (led_green),
    .led_blue  (led_blue)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;   // 0 PC, 1 reg, 2 RAM, 3 LEDs {r,g,b}
    int          idx;
    logic [31:0] exp;
  } chk_t;

  chk_t        st_q[$];
  logic [31:0] pc_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic        rst_q  = 1'b0;

  // final register values x1..x8 after the program reaches its halt loop
  logic [31:0] fin_x [1:8] = '{32'd5, 32'd3, 32'd8, 32'd0, 32'd9, 32'h2A, 32'd0, 32'h2A};

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] probe(input int kind, input int idx);
    case (kind)
      0:       return dut.PC;
      1:       return dut.R[idx];
      2:       return dut.RAM[idx];
      default: return {29'd0, led_red, led_green, led_blue};
    endcase
  endfunction

  task automatic expect_st(input string name, input int kind, input int idx, input logic [31:0] v);
    chk_t c;
    c.name = name; c.kind = kind; c.idx = idx; c.exp = v;
    st_q.push_back(c);
  endtask

  // n_run ticks stepping PC by 4, then n_halt ticks parked at 36
  task automatic push_trace(input int n_run, input int n_halt);
    for (int i = 1; i <= n_run; i++) pc_q.push_back(32'(4 * i));
    for (int i = 0; i < n_halt; i++) pc_q.push_back(32'd36);
  endtask

  task automatic push_final(input string tag);
    for (int i = 1; i <= 8; i++) expect_st($sformatf("%s_x%0d", tag, i), 1, i, fin_x[i]);
    expect_st({tag, "_ram0"}, 2, 0, 32'h2A);
    expect_st({tag, "_pc"},   0, 0, 32'd36);
    expect_st({tag, "_leds"}, 3, 0, 32'b011);
  endtask

  task automatic push_cleared(input string tag);
    for (int i = 1; i <= 8; i++) expect_st($sformatf("%s_x%0d", tag, i), 1, i, 32'd0);
    expect_st({tag, "_ram0"}, 2, 0, 32'd0);
    expect_st({tag, "_pc"},   0, 0, 32'd0);
    expect_st({tag, "_leds"}, 3, 0, 32'b111);
  endtask

  // monitor
  initial begin : monitor
    logic        prev_slow;
    logic [31:0] prev_pc;
    int          last_tick;
    chk_t        c;
    prev_slow = 1'b0;
    prev_pc   = '0;
    last_tick = -1;
    forever begin
      @(negedge clk);
      if (rst_q) last_tick = -1;
      if (dut.slow_clk && !prev_slow) begin
        if (pc_q.size() > 0) cmp("pc_trace", dut.PC, pc_q.pop_front());
        if (last_tick >= 0) cmp("tick_period", 32'(cyc - last_tick), 32'd16);
        last_tick = cyc;
      end else if (!rst_q) begin
        cmp("pc_stable", dut.PC, prev_pc);
      end
      prev_slow = dut.slow_clk;
      prev_pc   = dut.PC;
      while (st_q.size() > 0) begin
        c = st_q.pop_front();
        cmp(c.name, probe(c.kind, c.idx), c.exp);
      end
    end
  end

  task automatic pulse_reset_2clk();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 push_cleared("reset");
    @(negedge clk) rst = 1'b0;
  endtask

  // stimulus
  initial begin : stim
    bit found;
    // power-up state, RESET never asserted
    push_cleared("pwrup");
    push_trace(9, 11);
    repeat (320) @(posedge clk);
    #1 push_final("run1");
    repeat (2) @(negedge clk);
    cmp("run1_trace_drained", 32'(pc_q.size()), 32'd0);

    // reset after completion, then full re-run
    push_trace(9, 3);
    pulse_reset_2clk();
    repeat (192) @(posedge clk);
    #1 push_final("run2");
    repeat (2) @(negedge clk);
    cmp("run2_trace_drained", 32'(pc_q.size()), 32'd0);

    // reset landing on the tick that would execute addi x5 (PC=16)
    push_trace(4, 0);
    pulse_reset_2clk();
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (dut.PC == 32'd16) found = 1'b1;
    end
    if (!found) begin
      cmp("wait_pc16", dut.PC, 32'd16);
    end else begin
      repeat (15) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      expect_st("midrst_pc",   0, 0, 32'd0);
      expect_st("midrst_x5",   1, 5, 32'd0);
      expect_st("midrst_x3",   1, 3, 32'd0);
      expect_st("midrst_leds", 3, 0, 32'b111);
      @(negedge clk) rst = 1'b0;
      push_trace(5, 0);
      repeat (80) @(posedge clk);
      #1;
      expect_st("rerun_x5",   1, 5, 32'd9);
      expect_st("rerun_pc",   0, 0, 32'd20);
      expect_st("rerun_leds", 3, 0, 32'b011);
      repeat (2) @(negedge clk);
    end
    cmp("run3_trace_drained", 32'(pc_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
